// File: rtl/pad_driver_if.sv
// rtl/pad_driver_if.sv - CPU-side $4016 access bundle for pad_driver
//
// Purpose: groups the CPU-visible strobe/read signals of the controller port.
// Signals:
//   cpu_en     CPU enable; strobe_we and cpu_rd are acted on only when high
//   strobe_we  CPU write to $4016
//   strobe_d   bit0 of the CPU write data
//   cpu_rd     CPU read of $4016
//   cpu_dout   serial bit returned to the CPU (bit0 of the read data)
// Modports:
//   master  CPU side (drives enable/write/read, receives cpu_dout)
//   slave   pad_driver side

interface pad_driver_if;
    logic cpu_en;
    logic strobe_we;
    logic strobe_d;
    logic cpu_rd;
    logic cpu_dout;

    modport master (
        output cpu_en,
        output strobe_we,
        output strobe_d,
        output cpu_rd,
        input  cpu_dout
    );

    modport slave (
        input  cpu_en,
        input  strobe_we,
        input  strobe_d,
        input  cpu_rd,
        output cpu_dout
    );
endinterface

// File: rtl/pad_driver.sv
// rtl/pad_driver.sv - NES-style controller scanner with $4016 strobe/serial-read emulation
//
// Purpose: periodically scans a 4021-based controller through latch/clock/data
// pins, keeps the last complete 8-bit button state, and replays it to the CPU
// through the $4016 strobe / serial-read protocol.
// Ports:
//   clk            system clock (PPU domain)
//   reset          synchronous, active-high
//   cpu            pad_driver_if.slave: cpu_en, strobe_we, strobe_d, cpu_rd -> cpu_dout
//   pad_latch      controller latch pin
//   pad_clk_o      controller clock pin, idles high
//   pad_data       controller data pin, active-low
//   buttons        last complete scan, 1 = pressed (A,B,Sel,Start,Up,Down,Left,Right)
//   buttons_valid  one-clk pulse in the cycle buttons first shows a new scan

module pad_driver #(
    parameter int TICK_DIV    = 11,
    parameter int POLL_TICKS  = 8192,
    parameter int LATCH_TICKS = 2
) (
    input  logic         clk,
    input  logic         reset,
    pad_driver_if.slave  cpu,
    output logic         pad_latch,
    output logic         pad_clk_o,
    input  logic         pad_data,
    output logic [7:0]   buttons,
    output logic         buttons_valid
);

    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int POLL_W  = $clog2(POLL_TICKS);
    localparam int LCNT_W  = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;

    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_MAX  = POLL_W'(POLL_TICKS - 1);
    localparam logic [LCNT_W-1:0] LATCH_MAX = LCNT_W'(LATCH_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        CLK_LO,
        CLK_HI,
        DONE
    } scan_state_t;

    // ------------------------------------------------------------------
    // Pad tick generator: one tick per pad half-bit period
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    scan_state_t       state, state_d;
    logic [POLL_W-1:0] poll_cnt, poll_cnt_d;
    logic [LCNT_W-1:0] latch_cnt, latch_cnt_d;
    logic [2:0]        bit_idx, bit_idx_d;
    logic [7:0]        sample, sample_d;
    logic              scan_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            poll_cnt  <= '0;
            latch_cnt <= '0;
            bit_idx   <= '0;
            sample    <= '0;
        end else begin
            state     <= state_d;
            poll_cnt  <= poll_cnt_d;
            latch_cnt <= latch_cnt_d;
            bit_idx   <= bit_idx_d;
            sample    <= sample_d;
        end
    end

    always_comb begin
        state_d     = state;
        poll_cnt_d  = poll_cnt;
        latch_cnt_d = latch_cnt;
        bit_idx_d   = bit_idx;
        sample_d    = sample;
        scan_done   = 1'b0;

        unique case (state)
            IDLE: begin
                if (tick) begin
                    if (poll_cnt == POLL_MAX) begin
                        poll_cnt_d  = '0;
                        latch_cnt_d = '0;
                        state_d     = LATCH;
                    end else begin
                        poll_cnt_d = poll_cnt + POLL_W'(1);
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    if (latch_cnt == LATCH_MAX) begin
                        state_d = GAP;
                    end else begin
                        latch_cnt_d = latch_cnt + LCNT_W'(1);
                    end
                end
            end
            GAP: begin
                // The 4021 presents bit0 (A) as soon as the latch drops,
                // before any clock edge.
                if (tick) begin
                    sample_d[0] = ~pad_data;
                    bit_idx_d   = 3'd1;
                    state_d     = CLK_LO;
                end
            end
            CLK_LO: begin
                if (tick) begin
                    state_d = CLK_HI;
                end
            end
            CLK_HI: begin
                // Sample late in the high phase so the data pin has settled
                // after the rising edge shifted the next bit out.
                if (tick) begin
                    sample_d[bit_idx] = ~pad_data;
                    if (bit_idx == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                        state_d   = CLK_LO;
                    end
                end
            end
            DONE: begin
                // Single clk, not tick-qualified: publish and return to idle.
                scan_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin drivers are registered from the next state so the pins change on
    // the same edge as the FSM and never glitch on state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            pad_latch <= 1'b0;
            pad_clk_o <= 1'b1;
        end else begin
            pad_latch <= (state_d == LATCH);
            pad_clk_o <= (state_d != CLK_LO);
        end
    end

    // buttons only ever takes a complete sample; buttons_valid is aligned
    // with the first cycle the new value is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            buttons       <= 8'h00;
            buttons_valid <= 1'b0;
        end else begin
            buttons_valid <= scan_done;
            if (scan_done) begin
                buttons <= sample;
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU-visible $4016 emulation
    // ------------------------------------------------------------------
    logic       strobe;
    logic       rd_prev;
    logic [7:0] sr;
    logic       we_fire;
    logic       rd_fire;

    assign we_fire = cpu.strobe_we && cpu.cpu_en;
    // A held cpu_rd counts once; rd_prev tracks cpu_rd only on enabled
    // cycles so a read stretched over disabled cycles is still one read.
    assign rd_fire = cpu.cpu_rd && cpu.cpu_en && !rd_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe  <= 1'b0;
            rd_prev <= 1'b0;
            sr      <= 8'h00;
        end else begin
            if (we_fire) begin
                strobe <= cpu.strobe_d;
            end
            if (cpu.cpu_en) begin
                rd_prev <= cpu.cpu_rd;
            end
            // Reload wins over shift: while strobe is high, and also on a
            // write of 1 that collides with a read. The reload uses the
            // registered buttons, so a same-cycle scan publish is seen a
            // clk later.
            if (strobe || (we_fire && cpu.strobe_d)) begin
                sr <= buttons;
            end else if (rd_fire) begin
                sr <= {1'b1, sr[7:1]};
            end
        end
    end

    assign cpu.cpu_dout = sr[0];

endmodule

// File: tb/tb_pad_driver.sv
// tb/tb_pad_driver.sv - scoreboard testbench for pad_driver

module tb_pad_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pad_latch;
    logic       pad_clk_o;
    logic       pad_data;
    logic [7:0] buttons;
    logic       buttons_valid;

    always #5 clk = ~clk;

    pad_driver_if bus();

    pad_driver #(
        .TICK_DIV    (2),
        .POLL_TICKS  (40),
        .LATCH_TICKS (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu           (bus),
        .pad_latch     (pad_latch),
        .pad_clk_o     (pad_clk_o),
        .pad_data      (pad_data),
        .buttons       (buttons),
        .buttons_valid (buttons_valid)
    );

    int total = 0;
    int bad   = 0;

    // Controller model: 4021 parallel-loads while latch is high, shifts on
    // the rising edge of its clock, data pin is active-low.
    logic [7:0] pressed     = 8'hA5;
    logic [7:0] ctl_sr      = 8'hFF;
    logic       ctl_clk_prev = 1'b1;

    assign pad_data = ctl_sr[0];

    always @(posedge clk) begin
        if (pad_latch) begin
            ctl_sr <= ~pressed;
        end else if (pad_clk_o && !ctl_clk_prev) begin
            ctl_sr <= {1'b1, ctl_sr[7:1]};
        end
        ctl_clk_prev <= pad_clk_o;
    end

    // Scoreboards
    logic [7:0] exp_btn[$];
    logic       exp_rd[$];
    logic       latch_prev = 1'b0;
    logic       valid_prev = 1'b0;

    always @(negedge clk) begin
        logic [7:0] eb;
        logic       er;
        if (reset) begin
            exp_btn.delete();
        end else if (pad_latch && !latch_prev) begin
            exp_btn.push_back(pressed);
        end
        latch_prev <= pad_latch;

        if (valid_prev) begin
            total++;
            if (buttons_valid) begin
                bad++;
                $display("FAIL valid_width: buttons_valid=%0b, required 0 after one clk", buttons_valid);
            end
        end
        valid_prev <= buttons_valid;

        if (buttons_valid) begin
            total++;
            if (exp_btn.size() == 0) begin
                bad++;
                $display("FAIL buttons_unexpected: buttons=%02h with no scan expected", buttons);
            end else begin
                eb = exp_btn.pop_front();
                if (buttons !== eb) begin
                    bad++;
                    $display("FAIL buttons: got %02h, required %02h", buttons, eb);
                end
            end
        end

        if (bus.cpu_rd && bus.cpu_en) begin
            total++;
            if (exp_rd.size() == 0) begin
                bad++;
                $display("FAIL cpu_read_unexpected: cpu_dout=%0b", bus.cpu_dout);
            end else begin
                er = exp_rd.pop_front();
                if (bus.cpu_dout !== er) begin
                    bad++;
                    $display("FAIL cpu_read: got %0b, required %0b", bus.cpu_dout, er);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic d);
        @(posedge clk); #1;
        bus.strobe_we = 1'b1;
        bus.strobe_d  = d;
        @(posedge clk); #1;
        bus.strobe_we = 1'b0;
        bus.strobe_d  = 1'b0;
    endtask

    task automatic cpu_read(input logic e);
        @(posedge clk); #1;
        bus.cpu_rd = 1'b1;
        exp_rd.push_back(e);
        @(posedge clk); #1;
        bus.cpu_rd = 1'b0;
    endtask

    task automatic cpu_collide(input logic e);
        @(posedge clk); #1;
        bus.strobe_we = 1'b1;
        bus.strobe_d  = 1'b1;
        bus.cpu_rd    = 1'b1;
        exp_rd.push_back(e);
        @(posedge clk); #1;
        bus.strobe_we = 1'b0;
        bus.strobe_d  = 1'b0;
        bus.cpu_rd    = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!buttons_valid && n < 400);
        total++;
        if (!buttons_valid) begin
            bad++;
            $display("FAIL %s: no buttons_valid within %0d clk", name, n);
        end
    endtask

    task automatic wait_latch(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!pad_latch && n < 300);
    endtask

    initial begin
        int n;
        int lo_cnt;
        int rises;
        logic prev_clk;

        bus.cpu_en    = 1'b1;
        bus.strobe_we = 1'b0;
        bus.strobe_d  = 1'b0;
        bus.cpu_rd    = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Prime buttons=A5 and strobe=1 so the reset has something to clear
        pressed = 8'hA5;
        wait_valid("first_scan");
        cpu_write(1'b1);
        check("pre_reset_dout", {31'd0, bus.cpu_dout}, 32'd1);

        // Reset in the middle of the next scan (clock-low phase)
        wait_latch(n);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_pad_latch", {31'd0, pad_latch}, 32'd0);
        check("rst_pad_clk_o", {31'd0, pad_clk_o}, 32'd1);
        check("rst_buttons", {24'd0, buttons}, 32'h00);
        check("rst_cpu_dout", {31'd0, bus.cpu_dout}, 32'd0);
        check("rst_valid", {31'd0, buttons_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First scan after release: latch rises 80 clk later
        wait_latch(n);
        check("first_latch_delay", n, 32'd80);

        n = 1;
        while (n < 50) begin
            @(posedge clk); #1;
            if (!pad_latch) break;
            n++;
        end
        check("latch_width", n, 32'd4);

        lo_cnt   = 0;
        rises    = 0;
        prev_clk = pad_clk_o;
        n        = 0;
        while (!buttons_valid && n < 100) begin
            if (!pad_clk_o) lo_cnt++;
            if (pad_clk_o && !prev_clk) rises++;
            prev_clk = pad_clk_o;
            @(posedge clk); #1;
            n++;
        end
        check("scan_valid_seen", {31'd0, buttons_valid}, 32'd1);
        check("clk_low_cycles", lo_cnt, 32'd14);
        check("clk_pulses", rises, 32'd7);

        // CPU read sequence on 0xA5
        cpu_write(1'b1);
        cpu_write(1'b0);
        cpu_read(1'b1); cpu_read(1'b0); cpu_read(1'b1); cpu_read(1'b0);
        cpu_read(1'b0); cpu_read(1'b1); cpu_read(1'b0); cpu_read(1'b1);
        cpu_read(1'b1); cpu_read(1'b1);

        // Strobe held high
        pressed = 8'h01;
        wait_valid("scan_01");
        cpu_write(1'b1);
        cpu_read(1'b1); cpu_read(1'b1); cpu_read(1'b1);
        pressed = 8'h00;
        wait_valid("scan_00");
        check("strobe_dout_at_valid", {31'd0, bus.cpu_dout}, 32'd1);
        @(negedge clk);
        check("strobe_dout_after_valid", {31'd0, bus.cpu_dout}, 32'd0);

        // Snapshot isolation
        pressed = 8'hFF;
        wait_valid("scan_ff");
        cpu_write(1'b0);
        cpu_read(1'b1); cpu_read(1'b1); cpu_read(1'b1);
        pressed = 8'h00;
        wait_valid("scan_00_b");
        for (int i = 0; i < 6; i++) cpu_read(1'b1);

        // Gating and collision
        pressed = 8'hA5;
        wait_valid("scan_a5");
        cpu_write(1'b1);
        cpu_write(1'b0);
        cpu_read(1'b1);
        @(posedge clk); #1;
        bus.cpu_en = 1'b0;
        bus.cpu_rd = 1'b1;
        @(posedge clk); #1;
        bus.cpu_rd = 1'b0;
        bus.cpu_en = 1'b1;
        check("gated_no_shift", {31'd0, bus.cpu_dout}, 32'd0);
        cpu_read(1'b0);
        cpu_read(1'b1);
        cpu_collide(1'b0);
        check("collide_reload", {31'd0, bus.cpu_dout}, 32'd1);
        cpu_write(1'b0);
        cpu_read(1'b1);

        repeat (4) @(posedge clk);
        check("rd_queue_empty", exp_rd.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pad_driver.md
Name: pad_driver

Overview:
- Reads one NES-style controller (4021 serial shift register) through latch/clock/data pins.
- Scans the controller periodically and holds the last 8-bit button state.
- Emulates the CPU-visible $4016 strobe/serial-read behaviour from that stored state.
- Sits downstream of the clock generator in the same PPU clock domain; the CPU side is qualified by cpu_en.

Parameters:
TICK_DIV, 11, clk cycles per pad tick (pad half-bit period); must be >= 2
POLL_TICKS, 8192, pad ticks between scan starts (~60 Hz at defaults); must be > 17
LATCH_TICKS, 2, pad ticks pad_latch is held high

Ports:
clk  in  1  system clock (21.47MHz/4)
reset  in  1  synchronous, active-high reset
cpu_en  in  1  CPU enable; the CPU-side write and read are acted on only when cpu_en=1
strobe_we  in  1  CPU write to $4016
strobe_d  in  1  bit0 of the CPU write data
cpu_rd  in  1  CPU read of $4016 (one CPU cycle)
cpu_dout  out  1  serial bit returned to the CPU (bit0 of the read data)
pad_latch  out  1  controller latch pin
pad_clk_o  out  1  controller clock pin; idles high
pad_data  in  1  controller data pin; active-low (0 = pressed)
buttons  out  8  last scanned state, 1 = pressed; bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right
buttons_valid  out  1  one-clk pulse when buttons is updated

Behaviour:
- Tick generator
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle the counter equals TICK_DIV-1.
  - All scan FSM state changes happen only on tick.
- Poll counter
  - Counts ticks in IDLE.
  - Scan starts on the tick where the count reaches POLL_TICKS-1; the count then clears.
  - The first scan after reset starts POLL_TICKS ticks after reset is released.
- FSM states: IDLE -> LATCH -> GAP -> CLK_LO -> CLK_HI -> DONE -> IDLE.
  - IDLE: pad_latch=0, pad_clk_o=1.
  - LATCH: pad_latch=1 for LATCH_TICKS ticks, then go to GAP.
  - GAP: pad_latch=0 for 1 tick. At the end of GAP, sample ~pad_data into bit0.
  - CLK_LO: pad_clk_o=0 for 1 tick.
  - CLK_HI: pad_clk_o=1 for 1 tick. At the end of CLK_HI, sample ~pad_data into bit k (k=1..7).
  - Bit index 3 bits: after k=7, go to DONE; otherwise go back to CLK_LO.
  - DONE: lasts 1 clk (not 1 tick). Copy the sample register to buttons and assert buttons_valid for that clk.
  - Scan length is LATCH_TICKS+1+14 ticks (17 at defaults).
- buttons changes only in DONE; a partial scan never reaches buttons.
- CPU shift register (8 bits, sr)
  - strobe register is set from strobe_d when strobe_we && cpu_en.
  - While strobe=1, sr reloads from buttons every clk.
  - cpu_dout = sr[0] combinationally; it always reflects bit0 of sr. While strobe=1 this is buttons[0] (A).
  - On cpu_rd && cpu_en with strobe=0: sr shifts right one place and fills bit7 with 1. After 8 reads, all further reads return 1.
  - cpu_rd with strobe=1: no shift.
  - A read shifts only once, even if cpu_rd stays high across consecutive enabled cycles.
- Simultaneous events
  - strobe_we and cpu_rd in the same enabled cycle: the read returns the pre-update sr[0]. The write takes effect next; if strobe_d=1, sr reloads instead of shifting.
  - buttons update (DONE) while strobe=0: sr is not affected; a read sequence in progress continues on its old snapshot.
  - DONE and a strobe load in the same clk: sr loads the old buttons; the new value is loaded next clk if strobe is still 1.
- Reset (any time, including mid-scan)
  - Effective on the next clk edge.
  - pad_latch=0, pad_clk_o=1, buttons=0x00, buttons_valid=0.
  - sr=0x00, strobe=0, tick counter=0, poll counter=0, FSM=IDLE, sample register=0.

Test Plan:
- Reset and idle (TICK_DIV=2, POLL_TICKS=40): assert reset mid-operation -> next clk pad_latch=0, pad_clk_o=1, buttons=0x00, cpu_dout=0, buttons_valid=0. Release reset -> pad_latch rises exactly 80 clk later.
- Full scan: controller model drives pad_data=~0xA5 bits LSB-first -> latch high 4 clk, 7 low clock pulses of 2 clk each, buttons=0xA5, buttons_valid high exactly 1 clk.
- CPU read sequence: buttons=0xA5; write 1 then 0 to strobe; 10 enabled reads -> cpu_dout 1,0,1,0,0,1,0,1,1,1.
- Strobe held high: buttons=0x01; strobe=1; 3 reads -> cpu_dout 1,1,1; next scan with buttons=0x00 -> cpu_dout=0 one clk after DONE.
- Snapshot isolation: strobe=0 after latching 0xFF; 3 reads; a scan produces 0x00 -> remaining 5 reads return 1; the read after those returns 1.
- Gating and collision: cpu_rd with cpu_en=0 -> no shift. strobe_we(d=1) together with cpu_rd -> returns old sr[0], then sr=buttons.
